// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a start-timeout on each new grant and forced
// turnaround idle cycles between successive bus ownerships.
module bus_arbiter #(
   parameter int MASTER_COUNT   = 2,
   parameter int FIRST_PRIORITY = 0,
   parameter int START_TIMEOUT  = 16,
   parameter int TURNAROUND     = 1,
   localparam int ID_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MASTER_COUNT-1:0] req,
   input  logic [MASTER_COUNT-1:0] busy,
   output logic [MASTER_COUNT-1:0] grant,
   output logic [ID_W-1:0]         grant_id,
   output logic                    bus_idle,
   output logic                    timeout_evt
);

   localparam int CNT_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam int TCNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
   localparam logic [1:0] ST_OWNED     = 2'd2;
   localparam logic [1:0] ST_TURN      = 2'd3;

   localparam logic [MASTER_COUNT-1:0] ONE_HOT_0 = {{(MASTER_COUNT-1){1'b0}}, 1'b1};

   logic [1:0]              state_q, state_d;
   logic [MASTER_COUNT-1:0] grant_q, grant_d;
   logic [ID_W-1:0]         grant_id_q, grant_id_d;
   logic [ID_W-1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
   logic                    evt_q, evt_d;

   logic                    found;
   logic [ID_W-1:0]         pick;
   logic [ID_W-1:0]         idx;
   logic                    release_bus;
   logic [ID_W-1:0]         ptr_after_owner;

   // Search requesters starting at the round-robin pointer, wrapping at MASTER_COUNT.
   // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < MASTER_COUNT; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % MASTER_COUNT);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign ptr_after_owner = (grant_id_q == ID_W'(MASTER_COUNT - 1)) ? '0 : grant_id_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      evt_d       = 1'b0;
      release_bus = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d    = ONE_HOT_0 << pick;
               grant_id_d = pick;
               cnt_d      = '0;
               state_d    = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            if (busy[grant_id_q]) begin
               state_d = ST_OWNED;
            end else if (!req[grant_id_q]) begin
               release_bus = 1'b1;
            end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
               release_bus = 1'b1;
               evt_d       = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_OWNED: begin
            // Once the transfer has started the grantee keeps the bus until busy drops.
            if (!busy[grant_id_q]) begin
               release_bus = 1'b1;
            end
         end
         ST_TURN: begin
            if (tcnt_q == TCNT_W'(TURNAROUND - 1)) begin
               state_d = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      if (release_bus) begin
         grant_d = '0;
         state_d = ST_TURN;
         ptr_d   = ptr_after_owner;
         tcnt_d  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= ID_W'(FIRST_PRIORITY);
         cnt_q      <= '0;
         tcnt_q     <= '0;
         evt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         evt_q      <= evt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grant_id_q;
   assign bus_idle    = (state_q == ST_IDLE);
   assign timeout_evt = evt_q;

endmodule
